// File: rtl/slurm_mem_arbiter_pkg.sv
// slurm_mem_pkg: shared types and helpers for the slurm16 memory arbiter.
//   state_e      arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   ARB_FIXED    fixed priority, lowest master index wins
//   ARB_RR       round-robin starting after the last granted master
//   clog2()      index/counter width helper, never returns less than 1
package slurm_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Minimum of 1 so a single-master build still gets a legal 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/slurm_mem_arbiter_if.sv
// slurm_mem_arbiter_if: bundle of the master-side request bus and the
// memory-controller-side port of the arbiter.
//   M_RD/M_WR/M_ADDR/M_WDATA   per-master requests (packed, master i = slice i)
//   M_RDATA/M_ACK/M_ERR        completion back to the masters
//   memoryAddr/memoryOut/mem_RD/mem_WR   towards memory_controller
//   memBUSY/memoryIn           from memory_controller
// Modports:
//   slave  - the arbiter itself (serves the masters, drives the memory port)
//   master - the environment (bus masters plus memory controller)
interface slurm_mem_arbiter_if #(
  parameter int NUM_MASTERS  = 2,
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
);
  logic [NUM_MASTERS-1:0]              M_RD;
  logic [NUM_MASTERS-1:0]              M_WR;
  logic [NUM_MASTERS*ADDRESS_BITS-1:0] M_ADDR;
  logic [NUM_MASTERS*BITS-1:0]         M_WDATA;
  logic [BITS-1:0]                     M_RDATA;
  logic [NUM_MASTERS-1:0]              M_ACK;
  logic [NUM_MASTERS-1:0]              M_ERR;
  logic [ADDRESS_BITS-1:0]             memoryAddr;
  logic [BITS-1:0]                     memoryOut;
  logic                                mem_RD;
  logic                                mem_WR;
  logic                                memBUSY;
  logic [BITS-1:0]                     memoryIn;

  modport slave (
    input  M_RD, M_WR, M_ADDR, M_WDATA, memBUSY, memoryIn,
    output M_RDATA, M_ACK, M_ERR, memoryAddr, memoryOut, mem_RD, mem_WR
  );

  modport master (
    output M_RD, M_WR, M_ADDR, M_WDATA, memBUSY, memoryIn,
    input  M_RDATA, M_ACK, M_ERR, memoryAddr, memoryOut, mem_RD, mem_WR
  );
endinterface

// File: rtl/slurm_mem_arbiter_rr_picker.sv
// slurm_rr_picker: combinational grant selection.
//   req_i   request vector, one bit per master
//   ptr_i   last granted index (round-robin starts searching at ptr_i+1)
//   mode_i  ARB_FIXED (lowest index) or ARB_RR
//   gnt_o   selected master index (0 when nothing requested)
//   vld_o   at least one request present
module slurm_rr_picker
  import slurm_mem_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IW          = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          ptr_i,
  input  logic                   mode_i,
  output logic [IW-1:0]          gnt_o,
  output logic                   vld_o
);

  // Both searches walk from the lowest-preference candidate upward so the
  // last assignment made is the winner.
  always_comb begin
    gnt_o = '0;
    vld_o = |req_i;
    if (mode_i == ARB_FIXED) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (req_i[i]) gnt_o = IW'(i);
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--)
        if (req_i[(int'(ptr_i) + k) % NUM_MASTERS])
          gnt_o = IW'((int'(ptr_i) + k) % NUM_MASTERS);
    end
  end

endmodule

// File: rtl/slurm_mem_arbiter.sv
// slurm_mem_arbiter: N-master arbiter in front of memory_controller.
//   CLK   clock
//   RST   asynchronous active-high reset
//   bus   slurm_mem_arbiter_if.slave (master requests + memory port)
// One transaction at a time: IDLE picks a master and latches its request,
// ISSUE pulses the read/write strobe, WAIT holds the address until the slave
// drops memBUSY or the watchdog expires, DONE pulses M_ACK (and M_ERR on
// timeout). Every output comes straight from a flop.
module slurm_mem_arbiter
  import slurm_mem_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int BITS           = 16,
  parameter int ADDRESS_BITS   = 16,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             CLK,
  input logic             RST,
  slurm_mem_arbiter_if.slave bus
);

  localparam int IW = clog2(NUM_MASTERS);
  // Watchdog only needs to count 0 .. TIMEOUT_CYCLES-1.
  localparam int WW = clog2(TIMEOUT_CYCLES);

  state_e                  state_q;
  logic [IW-1:0]           gnt_q, ptr_q, pick_idx;
  logic                    pick_vld;
  logic                    op_wr_q;
  logic [WW-1:0]           wd_q;
  logic [NUM_MASTERS-1:0]  req, gnt_oh_d;
  logic [NUM_MASTERS-1:0]  ack_q, err_q;
  logic [BITS-1:0]         rdata_q, wdata_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic                    mem_rd_q, mem_wr_q;

  assign req      = bus.M_RD | bus.M_WR;
  assign gnt_oh_d = NUM_MASTERS'(1) << gnt_q;

  slurm_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .mode_i (ARB_MODE != 0),
    .gnt_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ptr_q    <= IW'(NUM_MASTERS - 1);   // master 0 is first after reset
      op_wr_q  <= 1'b0;
      wd_q     <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_q    <= pick_idx;
            ptr_q    <= pick_idx;
            addr_q   <= bus.M_ADDR[pick_idx*ADDRESS_BITS +: ADDRESS_BITS];
            wdata_q  <= bus.M_WDATA[pick_idx*BITS +: BITS];
            // Write takes precedence if a master raises both.
            op_wr_q  <= bus.M_WR[pick_idx];
            mem_wr_q <= bus.M_WR[pick_idx];
            mem_rd_q <= ~bus.M_WR[pick_idx];
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.memBUSY) begin
            if (!op_wr_q) rdata_q <= bus.memoryIn;
            ack_q   <= gnt_oh_d;
            state_q <= S_DONE;
          end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th busy cycle: give up.
            rdata_q <= '0;
            ack_q   <= gnt_oh_d;
            err_q   <= gnt_oh_d;
            wd_q    <= '0;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DONE: begin
          ack_q   <= '0;
          err_q   <= '0;
          wd_q    <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.M_RDATA    = rdata_q;
  assign bus.M_ACK      = ack_q;
  assign bus.M_ERR      = err_q;
  assign bus.memoryAddr = addr_q;
  assign bus.memoryOut  = wdata_q;
  assign bus.mem_RD     = mem_rd_q;
  assign bus.mem_WR     = mem_wr_q;

endmodule

// File: tb/tb_slurm_mem_arbiter.sv
// Randomized scoreboard bench for slurm_mem_arbiter (3 masters, round-robin,
// 8-cycle timeout) plus standalone checks of slurm_rr_picker in both modes.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_slurm_mem_arbiter;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int T  = 8;
  localparam int P  = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #(P/2) CLK = ~CLK;

  slurm_mem_arbiter_if #(.NUM_MASTERS(N), .BITS(DW), .ADDRESS_BITS(AW)) bus ();

  slurm_mem_arbiter #(.NUM_MASTERS(N), .BITS(DW), .ADDRESS_BITS(AW),
                      .ARB_MODE(1), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .bus(bus));

  logic [N-1:0] pk_req;
  logic [1:0]   pk_ptr, pk_fix_g, pk_rr_g;
  logic         pk_fix_v, pk_rr_v;
  slurm_rr_picker #(.NUM_MASTERS(N)) u_pk_fix (
    .req_i(pk_req), .ptr_i(pk_ptr), .mode_i(1'b0), .gnt_o(pk_fix_g), .vld_o(pk_fix_v));
  slurm_rr_picker #(.NUM_MASTERS(N)) u_pk_rr (
    .req_i(pk_req), .ptr_i(pk_ptr), .mode_i(1'b1), .gnt_o(pk_rr_g), .vld_o(pk_rr_v));

  typedef struct {
    int          m;
    bit          err;
    logic [DW-1:0] rdata;
    longint      t0;
    int          lat;
  } exp_t;

  int   ntests = 0;
  int   nfail  = 0;
  exp_t expq[$];
  exp_t mon_e;

  // Master model state: what each master is currently holding on the bus.
  bit            pend[N];
  bit            rdop[N];
  logic [AW-1:0] maddr[N];
  logic [DW-1:0] mdata[N];
  bit            en[N];
  int            gap[N];
  bit            cont, zero_wait;

  // Reference: last granted master and the value M_RDATA should hold.
  int            last_g;
  logic [DW-1:0] last_rdata;

  // Slave model.
  bit            inflight;
  int            cnt;
  int            force_b;
  bit            force_rd_v;
  logic [DW-1:0] force_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    ntests++;
    nfail++;
    $display("FAIL %s at t=%0t", nm, $time);
  endtask

  task automatic drive_bus();
    logic [N-1:0]    rd, wr;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      rd[i]          = pend[i] & rdop[i];
      wr[i]          = pend[i] & ~rdop[i];
      a[i*AW +: AW]  = maddr[i];
      d[i*DW +: DW]  = mdata[i];
    end
    bus.M_RD = rd; bus.M_WR = wr; bus.M_ADDR = a; bus.M_WDATA = d;
  endtask

  task automatic req_once(input int i, input bit rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    pend[i] = 1'b1; rdop[i] = rd; maddr[i] = a; mdata[i] = d;
    drive_bus();
  endtask

  // Round-robin rule: first pending master after the last granted one.
  function automatic int ref_pick();
    int r;
    r = -1;
    for (int k = N; k >= 1; k--)
      if (pend[(last_g + k) % N]) r = (last_g + k) % N;
    return r;
  endfunction

  // One falling edge: check a new strobe against the model, run the slave,
  // then advance every master.
  task automatic step();
    int   g, b;
    exp_t e;
    logic [DW-1:0] rdv;
    @(negedge CLK);
    if (bus.mem_RD || bus.mem_WR) begin
      if (inflight) fail("strobe_while_busy");
      else begin
        g = ref_pick();
        if (g < 0) fail("strobe_without_request");
        else begin
          chk("grant_op", {30'd0, bus.mem_RD, bus.mem_WR}, rdop[g] ? 32'd2 : 32'd1);
          chk("grant_addr", 32'(bus.memoryAddr), 32'(maddr[g]));
          if (!rdop[g]) chk("grant_wdata", 32'(bus.memoryOut), 32'(mdata[g]));
          if (force_b >= 0) begin b = force_b; force_b = -1; end
          else if (zero_wait) b = 0;
          else case ($urandom_range(0, 7))
            0: b = 0; 1: b = 1; 2: b = 2; 3: b = 3;
            4: b = T - 1; 5: b = T; 6: b = T + 4; default: b = 1;
          endcase
          rdv = force_rd_v ? force_rd : DW'($urandom);
          force_rd_v = 1'b0;
          e.m   = g;
          e.err = (b >= T);
          e.rdata = e.err ? '0 : (rdop[g] ? rdv : last_rdata);
          e.t0  = $time;
          e.lat = e.err ? T + 1 : b + 2;
          expq.push_back(e);
          last_rdata = e.rdata;
          last_g = g;
          inflight = 1'b1;
          cnt = b;
          bus.memBUSY  = 1'($urandom_range(0, 1));
          bus.memoryIn = rdv;
        end
      end
    end else if (inflight) begin
      bus.memBUSY = (cnt > 0);
      if (cnt > 0) cnt--;
    end else begin
      bus.memoryIn = DW'($urandom);
    end
    if (bus.M_ACK != '0) begin
      inflight = 1'b0; cnt = 0; bus.memBUSY = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i] && bus.M_ACK[i]) begin
        pend[i] = 1'b0;
        gap[i]  = cont ? 0 : int'($urandom_range(0, 6));
      end
      if (!pend[i] && en[i]) begin
        if (gap[i] == 0) begin
          pend[i] = 1'b1; rdop[i] = 1'($urandom_range(0, 1));
          maddr[i] = AW'($urandom); mdata[i] = DW'($urandom);
        end else gap[i]--;
      end
    end
    drive_bus();
  endtask

  task automatic wait_idle(input string nm);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 300) begin
      busy = inflight || (expq.size() != 0);
      for (int i = 0; i < N; i++) busy = busy || pend[i];
      if (busy) begin step(); n++; end
    end
    if (busy) fail(nm);
  endtask

  // Scoreboard monitor: every completion pops one expected transaction.
  always @(negedge CLK) begin
    if (!RST && (bus.M_ACK != '0 || bus.M_ERR != '0)) begin
      if (expq.size() == 0) begin
        fail("ack_unexpected");
      end else begin
        mon_e = expq.pop_front();
        chk("ack_onehot", 32'(bus.M_ACK), 32'(1 << mon_e.m));
        chk("ack_err", 32'(bus.M_ERR), mon_e.err ? 32'(1 << mon_e.m) : 32'd0);
        chk("ack_rdata", 32'(bus.M_RDATA), 32'(mon_e.rdata));
        chk("ack_latency", 32'(($time - mon_e.t0) / P), 32'(mon_e.lat));
      end
    end
  end

  always @(negedge CLK)
    assert (!(|(bus.M_RD & bus.M_WR))) else $error("protocol: RD and WR both set");

  initial begin
    #200000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int ef, er;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; rdop[i] = 0; maddr[i] = '0; mdata[i] = '0; en[i] = 0; gap[i] = 0;
    end
    cont = 0; zero_wait = 0; last_g = N - 1; last_rdata = '0;
    inflight = 0; cnt = 0; force_b = -1; force_rd_v = 0; force_rd = '0;
    bus.memBUSY = 1'b0; bus.memoryIn = '0;
    pk_req = '0; pk_ptr = '0;
    drive_bus();

    #22;
    chk("rst_ack",   32'(bus.M_ACK), 32'd0);
    chk("rst_err",   32'(bus.M_ERR), 32'd0);
    chk("rst_rdata", 32'(bus.M_RDATA), 32'd0);
    chk("rst_addr",  32'(bus.memoryAddr), 32'd0);
    chk("rst_wdata", 32'(bus.memoryOut), 32'd0);
    chk("rst_strb",  {30'd0, bus.mem_RD, bus.mem_WR}, 32'd0);

    // Picker unit checks, including 3'b101 (fixed starves master 2) and 3'b100.
    for (int v = 0; v < 24; v++) begin
      pk_req = (v < 8) ? N'(v) : N'($urandom);
      pk_ptr = 2'($urandom_range(0, N - 1));
      #1;
      ef = -1; er = -1;
      for (int i = N - 1; i >= 0; i--) if (pk_req[i]) ef = i;
      for (int k = N; k >= 1; k--) if (pk_req[(int'(pk_ptr) + k) % N]) er = (int'(pk_ptr) + k) % N;
      chk("pick_fix_vld", 32'(pk_fix_v), 32'(ef >= 0));
      chk("pick_rr_vld",  32'(pk_rr_v),  32'(er >= 0));
      if (ef >= 0) chk("pick_fix_gnt", 32'(pk_fix_g), 32'(ef));
      if (er >= 0) chk("pick_rr_gnt",  32'(pk_rr_g),  32'(er));
    end

    @(negedge CLK); #2 RST = 1'b0;

    // Single read: 3 busy cycles then 0xBEEF.
    force_b = 3; force_rd = 16'hBEEF; force_rd_v = 1;
    req_once(0, 1, 16'h1234, '0);
    wait_idle("bound_single_read");
    // Zero-wait write: M_RDATA must keep 0xBEEF.
    force_b = 0;
    req_once(1, 0, 16'h0040, 16'h5A5A);
    wait_idle("bound_write");

    // All masters requesting back to back on a zero-wait slave.
    cont = 1; zero_wait = 1;
    for (int i = 0; i < N; i++) begin en[i] = 1; gap[i] = 0; end
    repeat (40) step();
    for (int i = 0; i < N; i++) en[i] = 0;
    cont = 0; zero_wait = 0;
    wait_idle("bound_rr_drain");

    // Watchdog boundaries, a stuck slave on a write, then normal service.
    force_b = T - 1; req_once(2, 1, 16'h0A00, '0); wait_idle("bound_t_minus_1");
    force_b = T;     req_once(2, 1, 16'h0A01, '0); wait_idle("bound_t_exact");
    force_b = 3;     req_once(1, 1, 16'h0A02, '0); wait_idle("bound_refill");
    force_b = 40;    req_once(0, 0, 16'h0A03, 16'h1111); wait_idle("bound_stuck_wr");
    force_b = 1;     req_once(2, 1, 16'h0A04, '0); wait_idle("bound_after_to");

    // Random traffic.
    for (int i = 0; i < N; i++) begin en[i] = 1; gap[i] = int'($urandom_range(0, 4)); end
    repeat (400) step();
    for (int i = 0; i < N; i++) en[i] = 0;
    wait_idle("bound_random_drain");

    // Reset during WAIT with the slave stuck busy.
    force_b = 100;
    req_once(1, 1, 16'h0100, '0);
    begin
      int n;
      n = 0;
      while (!inflight && n < 50) begin step(); n++; end
      if (!inflight) fail("bound_rst_issue");
    end
    step(); step();
    req_once(0, 1, 16'h0200, '0);
    req_once(2, 0, 16'h0300, 16'hCAFE);
    #2 RST = 1'b1;
    #1;
    chk("arst_ack",   32'(bus.M_ACK), 32'd0);
    chk("arst_rdata", 32'(bus.M_RDATA), 32'd0);
    chk("arst_addr",  32'(bus.memoryAddr), 32'd0);
    chk("arst_strb",  {30'd0, bus.mem_RD, bus.mem_WR}, 32'd0);
    expq.delete();
    inflight = 0; cnt = 0; bus.memBUSY = 1'b0; force_b = -1;
    last_g = N - 1; last_rdata = '0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    // Masters still hold their requests; the model expects 0, 1, 2.
    wait_idle("bound_after_rst");

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
